// File: rtl/stopwatch_chain.sv
// rtl/stopwatch_chain.sv - BCD stopwatch: centisecond prescaler feeding a ces/sec/min counter chain
// Adds run/pause, clear, lap freeze, minute range limit and wrap/saturate overflow.
module stopwatch_chain #(
  parameter int DIV     = 10000,
  parameter int MAX_MIN = 59,
  parameter int WRAP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clr,
  input  logic       lap,
  output logic [3:0] min_X0,
  output logic [3:0] min_0X,
  output logic [3:0] sec_X0,
  output logic [3:0] sec_0X,
  output logic [3:0] ces_X0,
  output logic [3:0] ces_0X,
  output logic       held,
  output logic       overflow,
  output logic       sec_tick
);

  localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
  localparam logic [3:0]     MAX_T    = 4'(MAX_MIN / 10);
  localparam logic [3:0]     MAX_U    = 4'(MAX_MIN % 10);

  // Digit order, LSB first: ces_0X, ces_X0, sec_0X, sec_X0, min_0X, min_X0
  logic [5:0][3:0] live_q, live_d, snap_q, snap_d, live_inc;
  logic [PW-1:0]   pre_q, pre_d;
  logic            held_q, held_d;
  logic            ovf_q, ovf_d;
  logic            sec_tick_q, sec_tick_d;
  logic            tick, at_term, carry;

  assign tick    = run && (pre_q == PRE_LAST);
  assign at_term = (live_q[3:0] == 16'h5999) && (live_q[5] == MAX_T) && (live_q[4] == MAX_U);

  // Plain BCD increment; the terminal value is handled separately so minutes never exceed MAX_MIN
  always_comb begin
    live_inc = live_q;
    carry    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (carry) begin
        if (live_q[k] == ((k == 3) ? 4'd5 : 4'd9)) begin
          live_inc[k] = 4'd0;
        end else begin
          live_inc[k] = live_q[k] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (carry) begin
      if (live_q[4] == 4'd9) begin
        live_inc[4] = 4'd0;
        live_inc[5] = live_q[5] + 4'd1;
      end else begin
        live_inc[4] = live_q[4] + 4'd1;
      end
    end
  end

  always_comb begin
    pre_d      = pre_q;
    live_d     = live_q;
    snap_d     = snap_q;
    held_d     = held_q;
    ovf_d      = ovf_q;
    sec_tick_d = 1'b0;

    if (run) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    if (tick) begin
      if (at_term) begin
        ovf_d = 1'b1;
        if (WRAP != 0) begin
          live_d     = '0;
          sec_tick_d = 1'b1;
        end
      end else begin
        live_d     = live_inc;
        sec_tick_d = (live_inc[3:2] != live_q[3:2]);
      end
    end

    // Snapshot takes the pre-edge live value, so a tick on the same edge is not captured
    if (lap) begin
      if (!held_q) begin
        snap_d = live_q;
        held_d = 1'b1;
      end else begin
        held_d = 1'b0;
      end
    end

    if (clr) begin
      pre_d      = '0;
      live_d     = '0;
      snap_d     = '0;
      held_d     = 1'b0;
      ovf_d      = 1'b0;
      sec_tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      live_q     <= '0;
      snap_q     <= '0;
      held_q     <= 1'b0;
      ovf_q      <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      live_q     <= live_d;
      snap_q     <= snap_d;
      held_q     <= held_d;
      ovf_q      <= ovf_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X} = held_q ? snap_q : live_q;
  assign held     = held_q;
  assign overflow = ovf_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_stopwatch_chain.sv
// tb/tb_stopwatch_chain.sv - self-checking bench for stopwatch_chain against a centisecond-count model
// Three instances share stimulus: DIV=4/59/wrap, DIV=2/1/wrap, DIV=2/1/saturate.
module tb_stopwatch_chain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0, clr = 1'b0, lap = 1'b0;
  logic [23:0] d0, d1, d2;
  logic [2:0]  hld, ovf, stk;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopwatch_chain #(.DIV(4), .MAX_MIN(59), .WRAP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .lap(lap),
    .min_X0(d0[23:20]), .min_0X(d0[19:16]), .sec_X0(d0[15:12]), .sec_0X(d0[11:8]),
    .ces_X0(d0[7:4]), .ces_0X(d0[3:0]), .held(hld[0]), .overflow(ovf[0]), .sec_tick(stk[0]));

  stopwatch_chain #(.DIV(2), .MAX_MIN(1), .WRAP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .lap(lap),
    .min_X0(d1[23:20]), .min_0X(d1[19:16]), .sec_X0(d1[15:12]), .sec_0X(d1[11:8]),
    .ces_X0(d1[7:4]), .ces_0X(d1[3:0]), .held(hld[1]), .overflow(ovf[1]), .sec_tick(stk[1]));

  stopwatch_chain #(.DIV(2), .MAX_MIN(1), .WRAP(0)) u2 (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .lap(lap),
    .min_X0(d2[23:20]), .min_0X(d2[19:16]), .sec_X0(d2[15:12]), .sec_0X(d2[11:8]),
    .ces_X0(d2[7:4]), .ces_0X(d2[3:0]), .held(hld[2]), .overflow(ovf[2]), .sec_tick(stk[2]));

  // Model keeps elapsed time as a single centisecond count
  typedef struct {
    int pre;
    int tot;
    int snap;
    bit held;
    bit ovf;
    bit stk;
  } model_t;

  model_t m [3];

  function automatic model_t step(model_t s, int div, int maxm, bit wrap, bit r, bit c, bit l);
    model_t n;
    int term;
    bit t;
    n = s;
    n.stk = 1'b0;
    term = (maxm + 1) * 6000 - 1;
    if (c) begin
      n = '{default: 0};
      return n;
    end
    t = r && (s.pre == div - 1);
    if (r) n.pre = (s.pre == div - 1) ? 0 : s.pre + 1;
    if (t) begin
      if (s.tot == term) begin
        n.ovf = 1'b1;
        if (wrap) n.tot = 0;
      end else begin
        n.tot = s.tot + 1;
      end
      n.stk = ((n.tot / 100) % 60) != ((s.tot / 100) % 60);
    end
    if (l) begin
      if (!s.held) begin
        n.snap = s.tot;
        n.held = 1'b1;
      end else begin
        n.held = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
      m[2] <= '{default: 0};
    end else begin
      m[0] <= step(m[0], 4, 59, 1'b1, run, clr, lap);
      m[1] <= step(m[1], 2, 1, 1'b1, run, clr, lap);
      m[2] <= step(m[2], 2, 1, 1'b0, run, clr, lap);
    end
  end

  function automatic logic [23:0] bcd_of(int v);
    int mm, ss, cc;
    mm = v / 6000;
    ss = (v / 100) % 60;
    cc = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [23:0] exp_disp(int i);
    return bcd_of(m[i].held ? m[i].snap : m[i].tot);
  endfunction

  function automatic logic [23:0] dut_disp(int i);
    case (i)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b0; clr = 1'b0; lap = 1'b0;
    cyc(2);
    checks++;
    if ({d0, d1, d2} !== 72'h0) begin
      errs++;
      $display("FAIL reset_digits: got %h %h %h expected 000000", d0, d1, d2);
    end
    checks++;
    if ({hld, ovf, stk} !== 9'h0) begin
      errs++;
      $display("FAIL reset_flags: got held=%b ovf=%b stk=%b expected all 0", hld, ovf, stk);
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_first_second();
    int pulses = 0;
    int at = -1;
    do_clr();
    run = 1'b1;
    for (int e = 1; e <= 400; e++) begin
      cyc(1);
      if (stk[0] === 1'b1) begin
        pulses++;
        at = e;
      end
    end
    run = 1'b0;
    checks++;
    if (d0 !== 24'h000100) begin
      errs++;
      $display("FAIL first_second_disp: got %h expected 000100", d0);
    end
    checks++;
    if (pulses != 1 || at != 400) begin
      errs++;
      $display("FAIL first_second_tick: got %0d pulses last at edge %0d expected 1 at 400", pulses, at);
    end
  endtask

  task automatic test_pause();
    do_clr();
    run = 1'b1; cyc(10);
    run = 1'b0; cyc(20);
    run = 1'b1; cyc(2);
    run = 1'b0;
    checks++;
    if (d0 !== 24'h000003) begin
      errs++;
      $display("FAIL pause_disp: got %h expected 000003", d0);
    end
    checks++;
    if (u0.pre_q !== 2'd0) begin
      errs++;
      $display("FAIL pause_pre: got %0d expected 0", u0.pre_q);
    end
  endtask

  task automatic test_lap();
    int bad = 0;
    do_clr();
    run = 1'b1;
    cyc(20);
    checks++;
    if (d0 !== 24'h000005) begin
      errs++;
      $display("FAIL lap_start: got %h expected 000005", d0);
    end
    lap = 1'b1; cyc(1); lap = 1'b0;
    checks++;
    if (hld[0] !== 1'b1 || d0 !== 24'h000005) begin
      errs++;
      $display("FAIL lap_freeze: got held=%b disp=%h expected held=1 disp=000005", hld[0], d0);
    end
    for (int e = 0; e < 159; e++) begin
      cyc(1);
      if (hld[0] !== 1'b1 || d0 !== 24'h000005) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL lap_hold: got %0d cycles with changed display expected 0", bad);
    end
    run = 1'b0; lap = 1'b1; cyc(1); lap = 1'b0;
    checks++;
    if (hld[0] !== 1'b0 || d0 !== 24'h000045) begin
      errs++;
      $display("FAIL lap_release: got held=%b disp=%h expected held=0 disp=000045", hld[0], d0);
    end
  endtask

  task automatic test_clr_tick();
    do_clr();
    run = 1'b1;
    cyc(28);
    checks++;
    if (d0 !== 24'h000007) begin
      errs++;
      $display("FAIL clr_tick_pre: got %h expected 000007", d0);
    end
    cyc(3);
    clr = 1'b1; cyc(1); clr = 1'b0; run = 1'b0;
    checks++;
    if (d0 !== 24'h000000 || u0.pre_q !== 2'd0 || stk[0] !== 1'b0) begin
      errs++;
      $display("FAIL clr_tick: got disp=%h pre=%0d stk=%b expected 000000 0 0", d0, u0.pre_q, stk[0]);
    end
  endtask

  task automatic test_async_reset();
    do_clr();
    run = 1'b1;
    cyc(13);
    checks++;
    if (d0 !== 24'h000003) begin
      errs++;
      $display("FAIL areset_pre: got %h expected 000003", d0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d0, d1, d2} !== 72'h0 || {hld, ovf, stk} !== 9'h0) begin
      errs++;
      $display("FAIL areset_now: got %h %h %h flags %b expected all 0", d0, d1, d2, {hld, ovf, stk});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(3);
    checks++;
    if (d0 !== 24'h000000) begin
      errs++;
      $display("FAIL areset_early: got %h expected 000000", d0);
    end
    cyc(1);
    checks++;
    if (d0 !== 24'h000001) begin
      errs++;
      $display("FAIL areset_first: got %h expected 000001", d0);
    end
    run = 1'b0;
  endtask

  task automatic test_overflow();
    int sat_bad = 0;
    do_clr();
    run = 1'b1;
    cyc(23998);
    checks++;
    if (d1 !== 24'h015999 || d2 !== 24'h015999 || ovf[1] !== 1'b0 || ovf[2] !== 1'b0) begin
      errs++;
      $display("FAIL ovf_terminal: got %h %h ovf=%b%b expected 015999 015999 ovf=00", d1, d2, ovf[1], ovf[2]);
    end
    cyc(2);
    checks++;
    if (d1 !== 24'h000000 || ovf[1] !== 1'b1 || stk[1] !== 1'b1) begin
      errs++;
      $display("FAIL wrap_first: got %h ovf=%b stk=%b expected 000000 1 1", d1, ovf[1], stk[1]);
    end
    checks++;
    if (d2 !== 24'h015999 || ovf[2] !== 1'b1 || stk[2] !== 1'b0) begin
      errs++;
      $display("FAIL sat_first: got %h ovf=%b stk=%b expected 015999 1 0", d2, ovf[2], stk[2]);
    end
    for (int e = 0; e < 24000; e++) begin
      cyc(1);
      if (d2 !== 24'h015999 || stk[2] !== 1'b0 || ovf[2] !== 1'b1) sat_bad++;
    end
    checks++;
    if (d1 !== 24'h000000 || ovf[1] !== 1'b1) begin
      errs++;
      $display("FAIL wrap_second: got %h ovf=%b expected 000000 1", d1, ovf[1]);
    end
    checks++;
    if (sat_bad != 0) begin
      errs++;
      $display("FAIL sat_hold: got %0d bad cycles expected 0", sat_bad);
    end
    run = 1'b0;
    do_clr();
    checks++;
    if (d2 !== 24'h000000 || ovf[2] !== 1'b0 || ovf[1] !== 1'b0) begin
      errs++;
      $display("FAIL sat_clr: got %h ovf=%b%b expected 000000 ovf=00", d2, ovf[1], ovf[2]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      run = ($urandom_range(0, 9) < 7);
      lap = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 99) == 0);
      cyc(1);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dut_disp(i) !== exp_disp(i) || hld[i] !== m[i].held || ovf[i] !== m[i].ovf || stk[i] !== m[i].stk) begin
          errs++;
          $display("FAIL random_u%0d cycle %0d: got %h h%b o%b s%b expected %h h%b o%b s%b", i, c,
                   dut_disp(i), hld[i], ovf[i], stk[i], exp_disp(i), m[i].held, m[i].ovf, m[i].stk);
        end
      end
    end
    run = 1'b0; lap = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_second();
    test_pause();
    test_lap();
    test_clr_tick();
    test_async_reset();
    test_overflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
